// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
interface instruction_fetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Two-state instruction fetch unit: FETCH requests a word from memory, HOLD presents it
// to decode until consumed, then computes the next sequential or branch-target address.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                            clk,
  input  logic                            reset_n,
  instruction_fetch_unit_if.master        mem,
  output logic [31:0]                     instruction,
  output logic                            instr_valid,
  output logic [31:0]                     pc,
  input  logic                            stall,
  input  logic                            branch_taken,
  input  logic [31:0]                     branch_offset
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        req_en_q;
  logic [31:0] fetch_addr_q, fetch_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_req;
  logic [31:0] mem_addr;

  // Branch target is relative to pc+8; the word offset is scaled to bytes and wraps mod 2^32.
  function automatic logic [31:0] next_fetch_addr(input logic [31:0] cur_pc,
                                                  input logic        taken,
                                                  input logic signed [31:0] offset);
    logic [31:0] byte_off;
    logic [31:0] sum;
    byte_off = 32'(offset <<< 2);
    if (taken) sum = cur_pc + 32'd8 + byte_off;
    else       sum = cur_pc + 32'd4;
    return sum & 32'hFFFF_FFFC;
  endfunction

  // mem_req stays low during reset and the cycle it is released; req_en_q opens it on the first edge.
  assign mem_addr     = fetch_addr_q & 32'hFFFF_FFFC;
  assign mem.mem_req  = mem_req;
  assign mem.mem_addr = mem_addr;
  assign instruction  = instr_q;
  assign pc           = pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    mem_req      = 1'b0;
    instr_valid  = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req = req_en_q;
        if (req_en_q && mem.mem_ack) begin
          instr_d = mem.mem_rdata;
          pc_d    = mem_addr;
          state_d = HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (!stall) begin
          fetch_addr_d = next_fetch_addr(pc_q, branch_taken, branch_offset);
          state_d      = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH;
      req_en_q     <= 1'b0;
      fetch_addr_q <= RESET_PC;
      instr_q      <= 32'h0;
      pc_q         <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_en_q     <= 1'b1;
      fetch_addr_q <= fetch_addr_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, sequential stream, stall, branches, wrap, mid-fetch reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_unit_if mif ();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem           (mif),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From HOLD with the consume inputs already set: one FETCH cycle with an immediate ack.
  task automatic fetch_one(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
    step();
    check({tag, "_req"},   {31'h0, mif.mem_req}, 32'h1);
    check({tag, "_addr"},  mif.mem_addr, exp_addr);
    check({tag, "_fvld"},  {31'h0, instr_valid}, 32'h0);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = data;
    step();
    mif.mem_ack   = 1'b0;
    check({tag, "_vld"},   {31'h0, instr_valid}, 32'h1);
    check({tag, "_pc"},    pc, exp_addr);
    check({tag, "_instr"}, instruction, data);
    check({tag, "_hreq"},  {31'h0, mif.mem_req}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_req",   {31'h0, mif.mem_req}, 32'h0);
    check("rst_addr",  mif.mem_addr, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc",    pc, 32'h0);
    check("rst_vld",   {31'h0, instr_valid}, 32'h0);
    step();
    check("rst_req_clk", {31'h0, mif.mem_req}, 32'h0);
    reset_n = 1'b1;
    check("rel_req_pre", {31'h0, mif.mem_req}, 32'h0);

    // Ack after two wait cycles: three request cycles at address 0.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rel_req",  {31'h0, mif.mem_req}, 32'h1);
      check("rel_addr", mif.mem_addr, 32'h0);
      check("rel_vld",  {31'h0, instr_valid}, 32'h0);
    end
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hE3A0_0001;
    step();
    mif.mem_ack   = 1'b0;
    check("first_vld",   {31'h0, instr_valid}, 32'h1);
    check("first_pc",    pc, 32'h0);
    check("first_instr", instruction, 32'hE3A0_0001);
    check("first_req",   {31'h0, mif.mem_req}, 32'h0);

    fetch_one("seq4",  32'h0000_0004, 32'h1111_0004);
    fetch_one("seq8",  32'h0000_0008, 32'h1111_0008);
    fetch_one("seq12", 32'h0000_000C, 32'h1111_000C);

    // Stall in HOLD with noise on ack/rdata/branch inputs; all must be ignored.
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_offset = 32'h0000_0100;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_req",   {31'h0, mif.mem_req}, 32'h0);
      check("stall_vld",   {31'h0, instr_valid}, 32'h1);
      check("stall_pc",    pc, 32'h0000_000C);
      check("stall_instr", instruction, 32'h1111_000C);
    end
    stall        = 1'b0;
    mif.mem_ack  = 1'b0;
    branch_taken = 1'b0;
    fetch_one("after_stall", 32'h0000_0010, 32'h2222_0010);

    // 0x10 + 8 + 0x3A*4 = 0x100
    branch_taken  = 1'b1;
    branch_offset = 32'h0000_003A;
    fetch_one("br_to100", 32'h0000_0100, 32'h3333_0100);
    branch_offset = 32'hFFFF_FFFE;
    fetch_one("br_back", 32'h0000_0100, 32'h4444_0100);
    // 0x100 + 8 - 0xE8 = 0x20
    branch_offset = 32'hFFFF_FFC6;
    fetch_one("br_to20", 32'h0000_0020, 32'h5555_0020);
    branch_offset = 32'h0000_0010;
    fetch_one("br_fwd", 32'h0000_0068, 32'h6666_0068);
    // 0x68 + 8 - 0x74 wraps to 0xFFFFFFFC
    branch_offset = 32'hFFFF_FFE3;
    fetch_one("br_top", 32'hFFFF_FFFC, 32'h7777_FFFC);
    branch_taken = 1'b0;
    fetch_one("wrap", 32'h0000_0000, 32'h8888_0000);
    // Offset bits 31:30 are shifted out: behaves as +1 word.
    branch_taken  = 1'b1;
    branch_offset = 32'h4000_0001;
    fetch_one("br_hibits", 32'h0000_000C, 32'h9999_000C);

    // 0x0C + 8 + 0x0B*4 = 0x40, then reset in the middle of that fetch.
    branch_offset = 32'h0000_000B;
    step();
    check("pre_rst_addr", mif.mem_addr, 32'h0000_0040);
    check("pre_rst_req",  {31'h0, mif.mem_req}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_req",   {31'h0, mif.mem_req}, 32'h0);
    check("mid_rst_addr",  mif.mem_addr, 32'h0);
    check("mid_rst_instr", instruction, 32'h0);
    check("mid_rst_pc",    pc, 32'h0);
    check("mid_rst_vld",   {31'h0, instr_valid}, 32'h0);
    branch_taken = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("restart_req",  {31'h0, mif.mem_req}, 32'h1);
    check("restart_addr", mif.mem_addr, 32'h0);
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'hABCD_0000;
    step();
    mif.mem_ack   = 1'b0;
    check("restart_vld",   {31'h0, instr_valid}, 32'h1);
    check("restart_pc",    pc, 32'h0);
    check("restart_instr", instruction, 32'hABCD_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
